// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for an in-order pipeline of DEPTH stages beside issue.
// Latency: stall/fwd/wb_en combinational from inputs and state; tracking updates next CLK. Backpressure: hold freezes all tracking state.
// stall freezes fetch/issue and injects a bubble; flush kills the issuing instruction.
module pipe_hazard_ctrl #(
    parameter int DEPTH      = 4,
    parameter int LOAD_STAGE = 2,
    parameter int REG_AW     = 5,
    localparam int SELW      = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_en,
    input  logic              id_rs2_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              id_load,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic [SELW-1:0]   fwd_sel1,
    output logic [SELW-1:0]   fwd_sel2,
    output logic [DEPTH-2:0]  stage_valid,
    output logic              wb_en,
    output logic [31:0]       stall_cnt
);

    logic [DEPTH-1:1]  v_q;
    logic [DEPTH-1:1]  wr_q;
    logic [DEPTH-1:1]  ld_q;
    logic [REG_AW-1:0] rd_q [1:DEPTH-1];
    logic [31:0]       cnt_q;

    logic [SELW-1:0]   sel1;
    logic [SELW-1:0]   sel2;
    logic              rdy1;
    logic              rdy2;
    logic              hazard;

    // Scan oldest to youngest so the youngest producer's select and readiness win.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (v_q[k] && wr_q[k] && (rd_q[k] == id_rs1) && (id_rs1 != '0) && id_rs1_en) begin
                sel1 = SELW'(k);
                rdy1 = ~ld_q[k] | (k >= LOAD_STAGE);
            end
            if (v_q[k] && wr_q[k] && (rd_q[k] == id_rs2) && (id_rs2 != '0) && id_rs2_en) begin
                sel2 = SELW'(k);
                rdy2 = ~ld_q[k] | (k >= LOAD_STAGE);
            end
        end
        hazard = ~rdy1 | ~rdy2;
    end

    assign stall       = id_valid & ~flush & ~hold & ~Reset & hazard;
    assign fwd_sel1    = Reset ? '0 : sel1;
    assign fwd_sel2    = Reset ? '0 : sel2;
    assign stage_valid = Reset ? '0 : v_q;
    assign wb_en       = ~Reset & v_q[DEPTH-1] & wr_q[DEPTH-1];
    assign stall_cnt   = cnt_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            v_q   <= '0;
            wr_q  <= '0;
            ld_q  <= '0;
            cnt_q <= '0;
            for (int k = 1; k <= DEPTH - 1; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            if (!hold) begin
                v_q[1]  <= id_valid & ~stall & ~flush;
                rd_q[1] <= id_rd;
                wr_q[1] <= id_wr_en;
                ld_q[1] <= id_load;
                for (int k = 2; k <= DEPTH - 1; k++) begin
                    v_q[k]  <= v_q[k-1];
                    rd_q[k] <= rd_q[k-1];
                    wr_q[k] <= wr_q[k-1];
                    ld_q[k] <= ld_q[k-1];
                end
            end
            if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl at DEPTH=4, LOAD_STAGE=2.
module tb_pipe_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_en;
    logic       id_rs2_en;
    logic [4:0] id_rd;
    logic       id_wr_en;
    logic       id_load;
    logic       flush;
    logic       hold;
    logic       stall;
    logic [1:0] fwd_sel1;
    logic [1:0] fwd_sel2;
    logic [2:0] stage_valid;
    logic       wb_en;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(.DEPTH(4), .LOAD_STAGE(2), .REG_AW(5)) dut (
        .CLK(CLK), .Reset(Reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .id_rd(id_rd), .id_wr_en(id_wr_en), .id_load(id_load),
        .flush(flush), .hold(hold), .stall(stall),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stage_valid(stage_valid),
        .wb_en(wb_en), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst, vld;
        logic [4:0] rs1;
        logic       e1;
        logic [4:0] rs2;
        logic       e2;
        logic [4:0] rd;
        logic       wr, ld, fl, hd;
        logic       x_stall;
        logic [1:0] x_sel1, x_sel2;
        logic       chk_sel;
        logic [2:0] x_sv;
        logic       x_wb;
        logic [31:0] x_cnt;
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(input logic rst, vld, input int rs1, input logic e1,
                                input int rs2, input logic e2, input int rd,
                                input logic wr, ld, fl, hd, x_stall,
                                input int x_sel1, x_sel2, input logic chk_sel,
                                input logic [2:0] x_sv, input logic x_wb, input int x_cnt);
        vec_t v;
        v.rst = rst; v.vld = vld; v.rs1 = 5'(rs1); v.e1 = e1; v.rs2 = 5'(rs2); v.e2 = e2;
        v.rd = 5'(rd); v.wr = wr; v.ld = ld; v.fl = fl; v.hd = hd;
        v.x_stall = x_stall; v.x_sel1 = 2'(x_sel1); v.x_sel2 = 2'(x_sel2);
        v.chk_sel = chk_sel; v.x_sv = x_sv; v.x_wb = x_wb; v.x_cnt = 32'(x_cnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Reset = v.rst; id_valid = v.vld; id_rs1 = v.rs1; id_rs1_en = v.e1;
        id_rs2 = v.rs2; id_rs2_en = v.e2; id_rd = v.rd; id_wr_en = v.wr;
        id_load = v.ld; flush = v.fl; hold = v.hd;
    endtask

    initial begin
        //            rst vld rs1 e1 rs2 e2 rd wr ld fl hd | stall s1 s2 cs sv     wb cnt
        vecs[0]  = mk(1, 1,  5, 1,  5, 1,  6, 1, 0, 0, 0,  0, 0, 0, 1, 3'b000, 0, 0);
        vecs[1]  = mk(1, 1,  5, 1,  5, 1,  6, 1, 0, 0, 0,  0, 0, 0, 1, 3'b000, 0, 0);
        vecs[2]  = mk(0, 1,  1, 1,  2, 1,  5, 1, 0, 0, 0,  0, 0, 0, 1, 3'b000, 0, 0);
        vecs[3]  = mk(0, 1,  5, 1,  5, 1,  6, 1, 0, 0, 0,  0, 1, 1, 1, 3'b001, 0, 0);
        vecs[4]  = mk(0, 1,  5, 1,  6, 1,  9, 1, 0, 0, 0,  0, 2, 1, 1, 3'b011, 0, 0);
        vecs[5]  = mk(0, 1,  3, 1,  0, 0,  7, 1, 1, 0, 0,  0, 0, 0, 1, 3'b111, 1, 0);
        vecs[6]  = mk(0, 1,  7, 1,  6, 1,  8, 1, 0, 0, 0,  1, 0, 0, 0, 3'b111, 1, 0);
        vecs[7]  = mk(0, 1,  7, 1,  6, 1,  8, 1, 0, 0, 0,  0, 2, 0, 1, 3'b110, 1, 1);
        vecs[8]  = mk(0, 1,  1, 1,  2, 1,  0, 1, 0, 0, 0,  0, 0, 0, 1, 3'b101, 1, 1);
        vecs[9]  = mk(0, 1,  0, 1,  8, 0,  1, 1, 0, 0, 0,  0, 0, 0, 1, 3'b011, 0, 1);
        vecs[10] = mk(0, 1,  0, 0,  0, 0,  7, 1, 1, 0, 0,  0, 0, 0, 1, 3'b111, 1, 1);
        vecs[11] = mk(0, 1,  7, 1,  1, 1,  8, 1, 0, 1, 0,  0, 1, 2, 1, 3'b111, 1, 1);
        vecs[12] = mk(0, 0,  7, 1,  0, 0,  0, 0, 0, 0, 0,  0, 2, 0, 1, 3'b110, 1, 1);
        vecs[13] = mk(0, 1,  0, 0,  0, 0, 10, 1, 1, 0, 0,  0, 0, 0, 1, 3'b100, 1, 1);
        vecs[14] = mk(0, 1, 10, 1,  0, 0, 11, 1, 0, 0, 1,  0, 1, 0, 1, 3'b001, 0, 1);
        vecs[15] = mk(0, 1, 10, 1,  0, 0, 11, 1, 0, 0, 1,  0, 1, 0, 1, 3'b001, 0, 1);
        vecs[16] = mk(0, 1, 10, 1,  0, 0, 11, 1, 0, 0, 1,  0, 1, 0, 1, 3'b001, 0, 1);
        vecs[17] = mk(0, 1, 10, 1,  0, 0, 11, 1, 0, 0, 0,  1, 0, 0, 0, 3'b001, 0, 1);
        vecs[18] = mk(0, 1, 10, 1,  0, 0, 11, 1, 0, 0, 0,  0, 2, 0, 1, 3'b010, 0, 2);
        vecs[19] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1, 3'b101, 1, 2);
        vecs[20] = mk(0, 1,  0, 0,  0, 0, 12, 1, 1, 0, 0,  0, 0, 0, 1, 3'b010, 0, 2);
        vecs[21] = mk(1, 1, 12, 1,  0, 0, 13, 1, 0, 0, 0,  0, 0, 0, 1, 3'b000, 0, 2);
        vecs[22] = mk(0, 1, 12, 1,  0, 0, 13, 1, 0, 0, 0,  0, 0, 0, 1, 3'b000, 0, 0);
        vecs[23] = mk(0, 1,  0, 0,  0, 0, 13, 1, 1, 0, 0,  0, 0, 0, 1, 3'b001, 0, 0);
        vecs[24] = mk(0, 1, 13, 1,  0, 0, 14, 1, 0, 0, 0,  1, 0, 0, 0, 3'b011, 0, 0);
        vecs[25] = mk(0, 1, 13, 1,  0, 0, 14, 1, 0, 0, 0,  0, 2, 0, 1, 3'b110, 1, 1);

        // One unchecked reset edge so state and counter are defined before the table.
        drive(vecs[0]);
        @(posedge CLK);

        for (int i = 0; i < 26; i++) begin
            #1 drive(vecs[i]);
            #3;
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].x_stall));
            if (vecs[i].chk_sel) begin
                chk($sformatf("v%0d fwd_sel1", i), 32'(fwd_sel1), 32'(vecs[i].x_sel1));
                chk($sformatf("v%0d fwd_sel2", i), 32'(fwd_sel2), 32'(vecs[i].x_sel2));
            end
            chk($sformatf("v%0d stage_valid", i), 32'(stage_valid), 32'(vecs[i].x_sv));
            chk($sformatf("v%0d wb_en", i), 32'(wb_en), 32'(vecs[i].x_wb));
            chk($sformatf("v%0d stall_cnt", i), stall_cnt, vecs[i].x_cnt);
            @(posedge CLK);
        end

        // Drain: x14 walks to writeback and is forwarded from the last stage.
        #1 drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0));
        #3 chk("drain_a stage_valid", 32'(stage_valid), 32'h5);
        chk("drain_a wb_en", 32'(wb_en), 32'h1);
        @(posedge CLK);
        #4 chk("drain_b stage_valid", 32'(stage_valid), 32'h2);
        chk("drain_b wb_en", 32'(wb_en), 32'h0);
        @(posedge CLK);
        #1 drive(mk(0, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0));
        #3 chk("drain_c fwd_sel1 from writeback", 32'(fwd_sel1), 32'h3);
        chk("drain_c stall", 32'(stall), 32'h0);
        chk("drain_c wb_en", 32'(wb_en), 32'h1);
        @(posedge CLK);
        #1 drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0));
        #3 chk("drain_d stage_valid", 32'(stage_valid), 32'h1);
        chk("drain_d wb_en", 32'(wb_en), 32'h0);
        chk("drain_d stall_cnt", stall_cnt, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
